// File: rtl/hsv_ctrl_pkg.sv
// Shared definitions for the HSV front-panel controller: channel codes,
// channel limits, step FSM states and the per-channel step arithmetic.
package hsv_ctrl_pkg;

  localparam logic [1:0] CH_H = 2'd0;
  localparam logic [1:0] CH_S = 2'd1;
  localparam logic [1:0] CH_V = 2'd2;

  localparam logic [8:0] HUE_MAX = 9'd359;
  localparam logic [8:0] SV_MAX  = 9'd100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_REPEAT
  } step_state_e;

  // One +/-1 step on a channel: hue wraps around its circle, sat/val clamp.
  function automatic logic [8:0] step_value(input logic [8:0] value,
                                            input logic       up,
                                            input logic [8:0] max,
                                            input logic       wrap);
    if (up) begin
      if (value == max) return wrap ? 9'd0 : max;
      return value + 9'd1;
    end
    if (value == 9'd0) return wrap ? max : 9'd0;
    return value - 9'd1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and a
// one-cycle pulse when the accepted (clean) level goes high.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // Synchronize, count consecutive disagreeing cycles, flip the clean level.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop here samples pre-edge values.
    if (reset) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      rise <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= ~level;
        cnt   <= '0;
        rise  <= ~level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/hsv_edit_ctrl.sv
// Front-panel controller for the HSV colour registers: debounced buttons,
// channel select, single/auto-repeat steps and optional auto hue advance.
module hsv_edit_ctrl
  import hsv_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned HOLD_CYCLES     = 50000000,
  parameter int unsigned REPEAT_CYCLES   = 10000000,
  parameter int unsigned AUTO_HUE_CYCLES = 1048576
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_sel,
  input  logic       btn_up,
  input  logic       btn_dn,
  input  logic       auto_hue,
  output logic [1:0] sel,
  output logic [8:0] hue,
  output logic [8:0] sat,
  output logic [8:0] val,
  output logic       changed
);

  localparam int unsigned TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int unsigned AW   = (AUTO_HUE_CYCLES > 1) ? $clog2(AUTO_HUE_CYCLES) : 1;

  localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] REPEAT_LAST = TW'(REPEAT_CYCLES - 1);
  localparam logic [AW-1:0] AUTO_LAST   = AW'(AUTO_HUE_CYCLES - 1);

  // Select only needs its rise; its clean level has no consumer.
  logic sel_level_unused;
  logic sel_rise, up_level, up_rise, dn_level, dn_rise;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sel (
    .clk(clk), .reset(reset), .raw(btn_sel), .level(sel_level_unused), .rise(sel_rise));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk(clk), .reset(reset), .raw(btn_up), .level(up_level), .rise(up_rise));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dn (
    .clk(clk), .reset(reset), .raw(btn_dn), .level(dn_level), .rise(dn_rise));

  step_state_e   state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic          dir_up, dir_up_n;
  logic          step, step_up;
  logic          active_level;

  logic [AW-1:0] div, div_n;
  logic          auto_tick;
  logic [1:0]    sel_n;
  logic [8:0]    hue_n, sat_n, val_n;
  logic          changed_n;

  assign active_level = dir_up ? up_level : dn_level;

  // Step FSM: first step on a clean rise, then hold delay, then periodic repeat.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_n  = state;
    timer_n  = timer;
    dir_up_n = dir_up;
    step     = 1'b0;
    step_up  = dir_up;
    if (sel_rise || (up_level && dn_level)) begin
      state_n = ST_IDLE;
      timer_n = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (up_rise && !dn_level) begin
            step     = 1'b1;
            step_up  = 1'b1;
            dir_up_n = 1'b1;
            timer_n  = '0;
            state_n  = ST_HOLD;
          end else if (dn_rise && !up_level) begin
            step     = 1'b1;
            step_up  = 1'b0;
            dir_up_n = 1'b0;
            timer_n  = '0;
            state_n  = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!active_level) begin
            state_n = ST_IDLE;
          end else if (timer == HOLD_LAST) begin
            step    = 1'b1;
            timer_n = '0;
            state_n = ST_REPEAT;
          end else begin
            timer_n = timer + 1'b1;
          end
        end
        ST_REPEAT: begin
          if (!active_level) begin
            state_n = ST_IDLE;
          end else if (timer == REPEAT_LAST) begin
            step    = 1'b1;
            timer_n = '0;
          end else begin
            timer_n = timer + 1'b1;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // Channel next values: manual step, auto hue tick (dropped on a manual hue step).
  always_comb begin
    hue_n     = hue;
    sat_n     = sat;
    val_n     = val;
    div_n     = '0;
    auto_tick = 1'b0;
    sel_n     = sel;
    if (sel_rise) sel_n = (sel == CH_V) ? CH_H : sel + 2'd1;
    if (auto_hue) begin
      if (div == AUTO_LAST) auto_tick = 1'b1;
      else                  div_n     = div + 1'b1;
    end
    if (step) begin
      case (sel)
        CH_H:    hue_n = step_value(hue, step_up, HUE_MAX, 1'b1);
        CH_S:    sat_n = step_value(sat, step_up, SV_MAX, 1'b0);
        CH_V:    val_n = step_value(val, step_up, SV_MAX, 1'b0);
        default: ;
      endcase
    end
    if (auto_tick && !(step && (sel == CH_H))) hue_n = step_value(hue, 1'b1, HUE_MAX, 1'b1);
    changed_n = (hue_n != hue) || (sat_n != sat) || (val_n != val);
  end

  // State, timer, divider and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      timer   <= '0;
      dir_up  <= 1'b1;
      div     <= '0;
      sel     <= CH_H;
      hue     <= '0;
      sat     <= '0;
      val     <= '0;
      changed <= 1'b0;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      dir_up  <= dir_up_n;
      div     <= div_n;
      sel     <= sel_n;
      hue     <= hue_n;
      sat     <= sat_n;
      val     <= val_n;
      changed <= changed_n;
    end
  end

endmodule

// File: tb/tb_hsv_edit_ctrl.sv
// Directed bench for hsv_edit_ctrl with short timing parameters.
// Inputs are driven and outputs sampled on the falling edge.
module tb_hsv_edit_ctrl;

  logic       clk = 1'b0;
  logic       reset, btn_sel, btn_up, btn_dn, auto_hue;
  logic [1:0] sel;
  logic [8:0] hue, sat, val;
  logic       changed;

  int n_checks = 0;
  int n_fail = 0;
  int n_changed = 0;
  int base;

  hsv_edit_ctrl #(
    .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(20), .REPEAT_CYCLES(5), .AUTO_HUE_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset), .btn_sel(btn_sel), .btn_up(btn_up), .btn_dn(btn_dn),
    .auto_hue(auto_hue), .sel(sel), .hue(hue), .sat(sat), .val(val), .changed(changed)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (changed) n_changed++;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_btn(input int which, input logic v);
    case (which)
      0: btn_sel = v;
      1: btn_up  = v;
      default: btn_dn = v;
    endcase
  endtask

  // Single short press: long enough to debounce, short of the hold delay.
  task automatic press(input int which);
    set_btn(which, 1'b1);
    cyc(8);
    set_btn(which, 1'b0);
    cyc(8);
  endtask

  initial begin
    reset = 1'b1; btn_sel = 1'b0; btn_up = 1'b0; btn_dn = 1'b0; auto_hue = 1'b0;
    cyc(3);
    check("rst_sel", sel, 0);
    check("rst_hue", hue, 0);
    check("rst_sat", sat, 0);
    check("rst_val", val, 0);
    check("rst_changed", changed, 0);
    reset = 1'b0;
    cyc(2);

    // Glitch: 3 cycles high is shorter than the debounce window.
    btn_up = 1'b1; cyc(3); btn_up = 1'b0; cyc(12);
    check("glitch_hue", hue, 0);
    check("glitch_changed_cnt", n_changed, 0);

    // Single press: raw high from edge k, hue updates at edge k+6.
    btn_up = 1'b1;
    cyc(6);
    check("press_hue_before", hue, 0);
    cyc(1);
    check("press_hue_after", hue, 1);
    check("press_changed_hi", changed, 1);
    cyc(1);
    check("press_changed_lo", changed, 0);
    cyc(2); btn_up = 1'b0; cyc(12);
    check("press_hue_final", hue, 1);
    check("press_changed_cnt", n_changed, 1);

    // Hue wrap in both directions.
    press(2); check("hue_dn_to_0", hue, 0);
    press(2); check("hue_wrap_dn", hue, 359);
    press(1); check("hue_wrap_up", hue, 0);

    // Channel select cycling.
    press(0); check("sel_1", sel, 1);
    press(0); check("sel_2", sel, 2);
    press(0); check("sel_0", sel, 0);

    // Saturation: bring sat to 98, then hold up through hold and repeat.
    press(0);
    check("sel_s", sel, 1);
    repeat (98) press(1);
    check("sat_98", sat, 98);
    check("sat_hue_untouched", hue, 0);
    base = n_changed;
    btn_up = 1'b1;
    cyc(7);  check("sat_first_step", sat, 99);
    cyc(19); check("sat_before_repeat", sat, 99);
    cyc(1);  check("sat_repeat_100", sat, 100);
    cyc(5);  check("sat_saturated", sat, 100);
    cyc(8);  btn_up = 1'b0;
    cyc(15);
    check("sat_after_release", sat, 100);
    check("sat_changed_cnt", n_changed - base, 2);

    // Select pressed during REPEAT stops the repeating.
    press(0); press(0);
    check("sel_back_h", sel, 0);
    btn_up = 1'b1;
    cyc(7);  check("rep_step1", hue, 1);
    cyc(20); check("rep_step2", hue, 2);
    cyc(5);  check("rep_step3", hue, 3);
    cyc(1);  btn_sel = 1'b1;
    cyc(4);  check("rep_step4", hue, 4);
    cyc(13);
    check("rep_stopped_hue", hue, 4);
    check("rep_stopped_sel", sel, 1);
    btn_up = 1'b0; btn_sel = 1'b0;
    cyc(12);
    check("rep_release_hue", hue, 4);

    // Both buttons held: no step at all.
    press(0); press(0);
    btn_up = 1'b1; btn_dn = 1'b1;
    cyc(40);
    check("both_held_hue", hue, 4);
    btn_up = 1'b0; btn_dn = 1'b0;
    cyc(12);
    check("both_release_hue", hue, 4);
    check("both_sel", sel, 0);

    // Auto hue alone: one increment every 8 cycles.
    auto_hue = 1'b1;
    cyc(7);  check("auto_before_tick", hue, 4);
    cyc(1);  check("auto_tick1", hue, 5);
    check("auto_changed", changed, 1);
    cyc(8);  check("auto_tick2", hue, 6);
    auto_hue = 1'b0;
    cyc(10); check("auto_off_hold", hue, 6);

    // Collision: manual hue step lands on the divider terminal count.
    auto_hue = 1'b1;
    cyc(1);  btn_up = 1'b1;
    cyc(6);  check("coll_before", hue, 6);
    cyc(1);  check("coll_plus_one", hue, 7);
    auto_hue = 1'b0; btn_up = 1'b0;
    cyc(12);
    check("coll_final", hue, 7);

    // Reset mid-REPEAT with hue=sat=val=50.
    repeat (43) press(1);
    press(0);
    repeat (50) press(2);
    press(0);
    repeat (50) press(1);
    press(0);
    check("pre_rst_hue", hue, 50);
    check("pre_rst_sat", sat, 50);
    check("pre_rst_val", val, 50);
    check("pre_rst_sel", sel, 0);
    btn_up = 1'b1;
    cyc(7);  check("mid_step1", hue, 51);
    cyc(20); check("mid_step2", hue, 52);
    cyc(5);  check("mid_step3", hue, 53);
    cyc(2);
    reset = 1'b1;
    cyc(1);
    check("mid_rst_hue", hue, 0);
    check("mid_rst_sat", sat, 0);
    check("mid_rst_val", val, 0);
    check("mid_rst_sel", sel, 0);
    check("mid_rst_changed", changed, 0);
    cyc(10);
    check("mid_rst_held_hue", hue, 0);
    btn_up = 1'b0;
    cyc(2);
    reset = 1'b0;
    cyc(20);
    check("post_rst_hue", hue, 0);
    check("post_rst_changed", changed, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
